// File: rtl/divide_controller.sv
// Goldschmidt divide sequencer: steers k/N/D selects of the two-stage
// multiply datapath and forwards each product slice as the next operand.
module divide_controller #(
  parameter int WIDTH     = 16,
  parameter int ITERS     = 3,
  parameter int SLICE_LSB = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   n_in,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [WIDTH-1:0]   ia_in,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [WIDTH-1:0]   quotient,
  output logic               kSelect,
  output logic               ndSelect,
  output logic [WIDTH-1:0]   N,
  output logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   IA,
  input  logic [2*WIDTH-1:0] result
);

  localparam int IW = (ITERS < 4) ? 2 : $clog2(ITERS);

  typedef enum logic [2:0] {
    IDLE,
    S_D,
    S_N,
    DRAIN,
    FINISH,
    DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    it;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] ia_reg;
  logic [WIDTH-1:0] fb;

  assign fb = result[SLICE_LSB +: WIDTH];

  // Operands are forwarded straight from the product register so the
  // product landing this cycle feeds the very next issue slot.
  always_comb begin
    N  = '0;
    D  = '0;
    IA = '0;
    if (state == S_D) begin
      IA = ia_reg;
      D  = (it == '0) ? d_reg : fb;
    end
    if (state == S_N) begin
      N = (it == '0) ? n_reg : fb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      it       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      quotient <= '0;
      kSelect  <= 1'b0;
      ndSelect <= 1'b0;
      n_reg    <= '0;
      d_reg    <= '0;
      ia_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && d_in != '0) begin
            n_reg    <= n_in;
            d_reg    <= d_in;
            ia_reg   <= ia_in;
            it       <= '0;
            busy     <= 1'b1;
            kSelect  <= 1'b0;
            ndSelect <= 1'b0;
            state    <= S_D;
          end else if (start) begin
            busy     <= 1'b1;
            done     <= 1'b1;
            quotient <= '1;
            div_zero <= 1'b1;
            state    <= DONE;
          end
        end
        S_D: begin
          ndSelect <= 1'b1;
          state    <= S_N;
        end
        S_N: begin
          if (it == IW'(ITERS - 1)) begin
            state <= DRAIN;
          end else begin
            it       <= it + 1'b1;
            kSelect  <= 1'b1;
            ndSelect <= 1'b0;
            state    <= S_D;
          end
        end
        DRAIN: begin
          state <= FINISH;
        end
        FINISH: begin
          quotient <= fb;
          div_zero <= 1'b0;
          done     <= 1'b1;
          kSelect  <= 1'b0;
          ndSelect <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_controller.sv
// Bench for divide_controller: datapath model plus a transaction-level
// reference checked every cycle, with a few literal pins.
module tb_divide_controller;

  localparam int W  = 16;
  localparam int IT = 3;
  localparam int L  = 2 * IT + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  n_in = '0;
  logic [W-1:0]  d_in = '0;
  logic [W-1:0]  ia_in = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  quotient, N, D, IA;
  logic          kSelect, ndSelect;
  logic [2*W-1:0] result;

  always #5 clk = ~clk;

  divide_controller #(.WIDTH(W), .ITERS(IT), .SLICE_LSB(15)) dut (
    .clk(clk), .reset(reset), .start(start),
    .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .busy(busy), .done(done), .div_zero(div_zero),
    .quotient(quotient), .kSelect(kSelect), .ndSelect(ndSelect),
    .N(N), .D(D), .IA(IA), .result(result)
  );

  // two-stage datapath: k/operand registers, then product register
  logic [W-1:0] kreg, opreg;
  wire  [W-1:0] fb = result[30:15];

  always @(posedge clk) begin
    if (reset) begin
      kreg   <= '0;
      opreg  <= '0;
      result <= '0;
    end else begin
      if (!ndSelect)
        kreg <= kSelect ? 16'(17'h10000 - {1'b0, fb}) : IA;
      opreg  <= ndSelect ? N : D;
      result <= 32'(opreg) * 32'(kreg);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_quot(input logic [15:0] n,
      input logic [15:0] d, input logic [15:0] ia);
    int unsigned nn, dd, k;
    nn = n;
    dd = d;
    k  = ia;
    if (d == 0) return 16'hFFFF;
    for (int i = 0; i < IT; i++) begin
      if (i > 0) k = (32'h10000 - dd) & 32'hFFFF;
      nn = ((nn * k) >> 15) & 32'hFFFF;
      dd = ((dd * k) >> 15) & 32'hFFFF;
    end
    return nn[15:0];
  endfunction

  // transaction-level reference
  bit          active = 0;
  bit          z_m = 0;
  int          t0 = 0;
  logic [15:0] q_m = '0;
  logic [15:0] exp_q, n_l, d_l, ia_l;

  always @(negedge clk) begin
    int  k, lact;
    bit  e_busy, e_done, e_nd;
    lact = z_m ? 1 : L;
    if (active && (cyc - t0) > lact) active = 0;
    k = cyc - t0;
    if (cyc > 0) begin
      e_busy = active && k >= 1;
      e_done = active && k == lact;
      if (e_done) q_m = exp_q;
      e_nd = active && !z_m && k >= 1 && k <= 2 * IT + 2 &&
             (k > 2 * IT || k % 2 == 0);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("quotient", quotient, q_m);
      chk("ndSelect", ndSelect, e_nd);
      if (e_done) chk("div_zero", div_zero, z_m);
      if (!active || z_m)
        chk("kSelect_idle", kSelect, 0);
      else if (k >= 1 && k <= 2 * IT && k % 2 == 1)
        chk("kSelect", kSelect, k > 1);
      if (!e_busy) chk("ports_idle", {N, D, IA}, 0);
      if (active && !z_m && k == 1) chk("D_IA_first", {D, IA}, {d_l, ia_l});
      if (active && !z_m && k == 2) chk("N_first", N, n_l);
    end
    if (reset) begin
      active = 0;
      q_m = '0;
    end else if (start && !active) begin
      active = 1;
      t0     = cyc;
      n_l    = n_in;
      d_l    = d_in;
      ia_l   = ia_in;
      z_m    = (d_in == 0);
      exp_q  = ref_quot(n_in, d_in, ia_in);
    end
  end

  task automatic run(input logic [15:0] n, input logic [15:0] d,
                     input logic [15:0] ia, input int pulse_k,
                     output int lat, output logic [7:0] pat);
    @(posedge clk); #1;
    start = 1; n_in = n; d_in = d; ia_in = ia;
    @(posedge clk); #1;
    start = 0;
    n_in = 16'($urandom); d_in = 16'($urandom); ia_in = 16'($urandom);
    lat = -1;
    pat = '0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == pulse_k);
      @(negedge clk);
      if (k <= 8) pat[k-1] = ndSelect;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  int          lat, cnt;
  logic [7:0]  pat;
  logic [15:0] rn, rd, ria;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (5) @(negedge clk);
    chk("reset_state", {busy, done, kSelect, ndSelect, quotient}, 0);

    chk("model_pin_a", ref_quot(16'h6000, 16'h8000, 16'h8000), 16'h6000);
    chk("model_pin_b", ref_quot(16'h4000, 16'h6000, 16'hAAAB), 16'h5555);

    run(16'h6000, 16'h8000, 16'h8000, 0, lat, pat);
    chk("c2_latency", lat, 9);
    chk("c2_quot", quotient, 16'h6000);
    chk("c2_dz", div_zero, 0);

    run(16'h4000, 16'h6000, 16'hAAAB, 0, lat, pat);
    chk("c3_latency", lat, 9);
    chk("c3_ndpat", pat, 8'b1110_1010);
    chk("c3_tol", quotient >= 16'h5553 && quotient <= 16'h5557, 1);

    run(16'h1234, 16'h0000, 16'h5555, 0, lat, pat);
    chk("c4_latency", lat, 1);
    chk("c4_dz", div_zero, 1);
    chk("c4_quot", quotient, 16'hFFFF);

    run(16'h6000, 16'h8000, 16'h8000, 4, lat, pat);
    chk("c5_latency", lat, 9);
    chk("c5_quot", quotient, 16'h6000);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("c5_single_done", cnt, 0);

    @(posedge clk); #1;
    start = 1; n_in = 16'h4000; d_in = 16'h6000; ia_in = 16'hAAAB;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("c6_idle", {busy, done, quotient}, 0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("c6_no_done", cnt, 0);
    run(16'h4000, 16'h6000, 16'hAAAB, 0, lat, pat);
    chk("c6_restart_lat", lat, 9);
    chk("c6_restart_q", quotient, 16'h5555);

    repeat (25) begin
      rn  = 16'($urandom);
      ria = 16'($urandom);
      rd  = ($urandom_range(0, 7) == 0) ? 16'h0 : (16'h8000 | 16'($urandom));
      run(rn, rd, ria, $urandom_range(0, 12), lat, pat);
      chk("rnd_latency", lat, (rd == 0) ? 1 : 9);
      chk("rnd_quot", quotient, ref_quot(rn, rd, ria));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
